// File: rtl/fifo_drain_scoreboard_if.sv
// Core-side write/read observation bus for the FIFO drain scoreboard.
// The core (or a bench standing in for it) drives; the scoreboard only listens.
interface fifo_drain_scoreboard_if #(
  parameter int unsigned DW = 16
);
  logic          wen;
  logic [DW-1:0] wdata;
  logic          ren;
  logic          valid_out;
  logic [DW-1:0] rdata;

  modport master (output wen, output wdata, output ren, output valid_out, output rdata);
  modport slave  (input  wen, input  wdata, input  ren, input  valid_out, input  rdata);
endinterface

// File: rtl/fifo_drain_scoreboard.sv
// Shadow-FIFO checker for the memory core in FIFO mode: in-order data compare,
// sticky overflow/underflow/mismatch/timeout flags and first-mismatch capture.
module fifo_drain_scoreboard #(
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_DEPTH = 64,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic [15:0]            depth,
  fifo_drain_scoreboard_if.slave bus,
  output logic [15:0]            occupancy,
  output logic                   mismatch,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   timeout,
  output logic [DW-1:0]          exp_data,
  output logic [DW-1:0]          act_data,
  output logic [31:0]            pop_count
);
  localparam int unsigned AW = $clog2(MAX_DEPTH);
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] mem_q [MAX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]   occ_q, occ_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          ren_d1_q;
  logic          mis_q, mis_d, over_q, over_d, under_q, under_d, tmo_q, tmo_d;
  logic [DW-1:0] exp_q, exp_d, act_q, act_d;
  logic [31:0]   pops_q, pops_d;

  logic pop_req, empty, full, pop_ok, push_ok, under_ev, over_ev, mis_ev, live;

  always_comb begin
    pop_req  = ren_d1_q && bus.valid_out;
    empty    = (occ_q == '0);
    full     = (occ_q == depth);
    pop_ok   = pop_req && !empty;
    under_ev = pop_req && empty;
    // A pop in the same cycle frees the slot, so a push at full is legal then.
    push_ok  = bus.wen && (!full || pop_ok);
    over_ev  = bus.wen && full && !pop_ok;
    mis_ev   = pop_ok && (bus.rdata != mem_q[rd_ptr_q]);
    live     = (state_q != ERR);

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    pops_d   = pop_ok  ? pops_q + 32'd1  : pops_q;

    occ_d = occ_q;
    unique case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + 16'd1;
      2'b01:   occ_d = occ_q - 16'd1;
      default: occ_d = occ_q;
    endcase

    stall_d = stall_q;
    if (pop_ok || empty)           stall_d = '0;
    else if (stall_q != SW'(TIMEOUT)) stall_d = stall_q + 1'b1;

    mis_d   = mis_q;
    over_d  = over_q;
    under_d = under_q;
    tmo_d   = tmo_q;
    exp_d   = exp_q;
    act_d   = act_q;
    if (live) begin
      over_d  = over_q  | over_ev;
      under_d = under_q | under_ev;
      tmo_d   = tmo_q   | (stall_d == SW'(TIMEOUT));
      mis_d   = mis_q   | mis_ev;
      if (mis_ev && !mis_q) begin
        exp_d = mem_q[rd_ptr_q];
        act_d = bus.rdata;
      end
    end

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mis_d || over_d || under_d || tmo_d) state_d = ERR;
        else if (bus.wen)                        state_d = RUN;
      end
      RUN:     if (mis_d || over_d || under_d || tmo_d) state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      stall_q  <= '0;
      ren_d1_q <= 1'b0;
      mis_q    <= 1'b0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      tmo_q    <= 1'b0;
      exp_q    <= '0;
      act_q    <= '0;
      pops_q   <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      stall_q  <= stall_d;
      ren_d1_q <= bus.ren;
      mis_q    <= mis_d;
      over_q   <= over_d;
      under_q  <= under_d;
      tmo_q    <= tmo_d;
      exp_q    <= exp_d;
      act_q    <= act_d;
      pops_q   <= pops_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && clk_en && push_ok) mem_q[wr_ptr_q] <= bus.wdata;
  end

  assign occupancy = occ_q;
  assign mismatch  = mis_q;
  assign overflow  = over_q;
  assign underflow = under_q;
  assign timeout   = tmo_q;
  assign exp_data  = exp_q;
  assign act_data  = act_q;
  assign pop_count = pops_q;
endmodule

// File: tb/tb_fifo_drain_scoreboard.sv
// Directed bench for fifo_drain_scoreboard; the bench plays the memory core
// (read data returned one cycle after ren).
module tb_fifo_drain_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [15:0] depth;
  logic [15:0] occupancy;
  logic        mismatch, overflow, underflow, timeout;
  logic [15:0] exp_data, act_data;
  logic [31:0] pop_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  fifo_drain_scoreboard_if #(.DW(16)) bus ();

  fifo_drain_scoreboard #(.DW(16), .MAX_DEPTH(64), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .depth     (depth),
    .bus       (bus),
    .occupancy (occupancy),
    .mismatch  (mismatch),
    .overflow  (overflow),
    .underflow (underflow),
    .timeout   (timeout),
    .exp_data  (exp_data),
    .act_data  (act_data),
    .pop_count (pop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] wd, input logic r,
                       input logic v, input logic [15:0] rd);
    bus.wen = w; bus.wdata = wd; bus.ren = r; bus.valid_out = v; bus.rdata = rd;
    step();
  endtask

  task automatic do_reset(input logic [15:0] d);
    depth  = d;
    clk_en = 1'b1;
    bus.wen = 0; bus.wdata = '0; bus.ren = 0; bus.valid_out = 0; bus.rdata = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(16'd4);
    n_cmp++; if (occupancy !== 16'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_cmp++; if ({mismatch, overflow, underflow, timeout} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {mismatch, overflow, underflow, timeout}); end
    n_cmp++; if ({exp_data, act_data} !== 32'd0) begin n_fail++; $display("FAIL reset_capture got %h want 0", {exp_data, act_data}); end
    n_cmp++; if (pop_count !== 32'd0) begin n_fail++; $display("FAIL reset_pops got %0d want 0", pop_count); end
  endtask

  task automatic test_in_order();
    do_reset(16'd4);
    drive(1, 16'h0011, 0, 0, 16'h0);
    drive(1, 16'h0022, 0, 0, 16'h0);
    drive(1, 16'h0033, 0, 0, 16'h0);
    n_cmp++; if (occupancy !== 16'd3) begin n_fail++; $display("FAIL inorder_fill got %0d want 3", occupancy); end
    drive(0, 16'h0, 1, 0, 16'h0000);
    drive(0, 16'h0, 1, 1, 16'h0011);
    drive(0, 16'h0, 1, 1, 16'h0022);
    drive(0, 16'h0, 0, 1, 16'h0033);
    drive(0, 16'h0, 0, 0, 16'h0000);
    n_cmp++; if ({mismatch, overflow, underflow, timeout} !== 4'b0000) begin n_fail++; $display("FAIL inorder_flags got %b want 0000", {mismatch, overflow, underflow, timeout}); end
    n_cmp++; if (pop_count !== 32'd3) begin n_fail++; $display("FAIL inorder_pops got %0d want 3", pop_count); end
    n_cmp++; if (occupancy !== 16'd0) begin n_fail++; $display("FAIL inorder_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_overflow();
    do_reset(16'd4);
    for (int i = 0; i < 4; i++) drive(1, 16'(i + 1), 0, 0, 16'h0);
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full got %b want 0", overflow); end
    n_cmp++; if (occupancy !== 16'd4) begin n_fail++; $display("FAIL ovf_full_occ got %0d want 4", occupancy); end
    drive(1, 16'h0005, 0, 0, 16'h0);
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_fifth got %b want 1", overflow); end
    n_cmp++; if (occupancy !== 16'd4) begin n_fail++; $display("FAIL ovf_occ got %0d want 4", occupancy); end
  endtask

  task automatic test_underflow();
    do_reset(16'd4);
    drive(0, 16'h0, 0, 1, 16'h1234);
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_stray_valid got %b want 0", underflow); end
    drive(0, 16'h0, 1, 0, 16'h0);
    drive(0, 16'h0, 0, 1, 16'h0);
    n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b want 1", underflow); end
    n_cmp++; if (occupancy !== 16'd0) begin n_fail++; $display("FAIL unf_occ got %0d want 0", occupancy); end
    n_cmp++; if (pop_count !== 32'd0) begin n_fail++; $display("FAIL unf_pops got %0d want 0", pop_count); end
  endtask

  task automatic test_mismatch();
    do_reset(16'd4);
    drive(1, 16'hAAAA, 0, 0, 16'h0);
    drive(0, 16'h0, 1, 0, 16'h0);
    drive(0, 16'h0, 0, 1, 16'hAAAB);
    n_cmp++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b want 1", mismatch); end
    n_cmp++; if (exp_data !== 16'hAAAA) begin n_fail++; $display("FAIL mis_exp got %h want aaaa", exp_data); end
    n_cmp++; if (act_data !== 16'hAAAB) begin n_fail++; $display("FAIL mis_act got %h want aaab", act_data); end
    n_cmp++; if (pop_count !== 32'd1) begin n_fail++; $display("FAIL mis_pops got %0d want 1", pop_count); end
    // In ERR the flags are frozen: an empty pop must not raise underflow.
    drive(0, 16'h0, 1, 0, 16'h0);
    drive(0, 16'h0, 0, 1, 16'h5555);
    n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL err_frozen_unf got %b want 0", underflow); end
    drive(1, 16'h1234, 0, 0, 16'h0);
    drive(0, 16'h0, 1, 0, 16'h0);
    drive(0, 16'h0, 0, 1, 16'h9999);
    n_cmp++; if ({exp_data, act_data} !== 32'hAAAA_AAAB) begin n_fail++; $display("FAIL err_capture_held got %h want aaaaaaab", {exp_data, act_data}); end
    n_cmp++; if (pop_count !== 32'd2) begin n_fail++; $display("FAIL err_pops_track got %0d want 2", pop_count); end
  endtask

  task automatic test_timeout();
    do_reset(16'd4);
    drive(1, 16'h0042, 0, 0, 16'h0);
    for (int i = 0; i < 7; i++) drive(0, 16'h0, 0, 0, 16'h0);
    n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %b want 0", timeout); end
    drive(0, 16'h0, 0, 0, 16'h0);
    n_cmp++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_at_8 got %b want 1", timeout); end
  endtask

  task automatic test_back_to_back();
    do_reset(16'd2);
    drive(1, 16'h00A1, 0, 0, 16'h0);
    drive(1, 16'h00A2, 1, 0, 16'h0);
    n_cmp++; if (occupancy !== 16'd2) begin n_fail++; $display("FAIL b2b_occ_full got %0d want 2", occupancy); end
    drive(1, 16'h00A3, 0, 1, 16'h00A1);
    n_cmp++; if (occupancy !== 16'd2) begin n_fail++; $display("FAIL b2b_occ_pushpop got %0d want 2", occupancy); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_no_ovf got %b want 0", overflow); end
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 16'hDEAD, 1, 1, 16'hBEEF);
    clk_en = 1'b1;
    n_cmp++; if (occupancy !== 16'd2) begin n_fail++; $display("FAIL b2b_occ_hold got %0d want 2", occupancy); end
    n_cmp++; if (pop_count !== 32'd1) begin n_fail++; $display("FAIL b2b_pops_hold got %0d want 1", pop_count); end
    drive(0, 16'h0, 1, 0, 16'h0);
    drive(0, 16'h0, 1, 1, 16'h00A2);
    drive(0, 16'h0, 0, 1, 16'h00A3);
    n_cmp++; if (occupancy !== 16'd0) begin n_fail++; $display("FAIL b2b_occ_drained got %0d want 0", occupancy); end
    n_cmp++; if ({mismatch, overflow, underflow, timeout} !== 4'b0000) begin n_fail++; $display("FAIL b2b_flags got %b want 0000", {mismatch, overflow, underflow, timeout}); end
    n_cmp++; if (pop_count !== 32'd3) begin n_fail++; $display("FAIL b2b_pops got %0d want 3", pop_count); end
    drive(1, 16'h0077, 0, 0, 16'h0);
    drive(1, 16'h0078, 0, 0, 16'h0);
    drive(1, 16'h0079, 0, 0, 16'h0);
    reset = 1'b1;
    drive(0, 16'h0, 0, 0, 16'h0);
    reset = 1'b0;
    n_cmp++; if ({occupancy, mismatch, overflow, underflow, timeout, exp_data, act_data, pop_count} !== 84'd0) begin
      n_fail++; $display("FAIL midreset_outputs got occ=%0d flags=%b pops=%0d want all 0", occupancy, {mismatch, overflow, underflow, timeout}, pop_count);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_overflow();
    test_underflow();
    test_mismatch();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
